// File: rtl/keyboard.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver: synchronises ps2c/ps2d, assembles 11-bit frames, keeps the last two
// accepted frames and shows both data bytes on four active-low seven-segment displays.
module keyboard #(
    parameter int unsigned TIMEOUT_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [6:0] prev_seg1,
    output logic [6:0] prev_seg0,
    output logic [6:0] curr_seg1,
    output logic [6:0] curr_seg0
);
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYCLES);

    logic           ps2c_meta_q, ps2c_sync_q, ps2c_prev_q;
    logic           ps2d_meta_q, ps2d_sync_q;
    logic [10:0]    shift_q;
    logic [3:0]     bit_cnt_q;
    logic [WdW-1:0] wdog_q;
    logic [10:0]    out_currb;
    logic [10:0]    out_prevb;

    logic           fall;
    logic [10:0]    frame;
    logic           frame_ok;

    assign fall     = ps2c_prev_q & ~ps2c_sync_q;
    // The incoming bit enters at the top, so after 11 shifts bit0 holds the start bit.
    assign frame    = {ps2d_sync_q, shift_q[10:1]};
    assign frame_ok = (frame[0] == 1'b0) && (frame[9] == ~^frame[8:1]);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps2c_meta_q <= 1'b1;
            ps2c_sync_q <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_meta_q <= 1'b1;
            ps2d_sync_q <= 1'b1;
        end else begin
            ps2c_meta_q <= ps2c;
            ps2c_sync_q <= ps2c_meta_q;
            ps2c_prev_q <= ps2c_sync_q;
            ps2d_meta_q <= ps2d;
            ps2d_sync_q <= ps2d_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            wdog_q    <= '0;
            out_currb <= '0;
            out_prevb <= '0;
        end else if (fall) begin
            shift_q <= frame;
            wdog_q  <= '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_q <= '0;
                if (frame_ok) begin
                    out_prevb <= out_currb;
                    out_currb <= frame;
                end
            end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
        end else begin
            if (wdog_q != WdMax) begin
                wdog_q <= wdog_q + 1'b1;
            end
            // A stalled device leaves a partial frame behind; drop it so the next start bit aligns.
            if (bit_cnt_q != 4'd0 && wdog_q == WdMax) begin
                bit_cnt_q <= '0;
                shift_q   <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curr_seg1 <= 7'h40;
            curr_seg0 <= 7'h40;
            prev_seg1 <= 7'h40;
            prev_seg0 <= 7'h40;
        end else begin
            curr_seg1 <= hex7(out_currb[8:5]);
            curr_seg0 <= hex7(out_currb[4:1]);
            prev_seg1 <= hex7(out_prevb[8:5]);
            prev_seg0 <= hex7(out_prevb[4:1]);
        end
    end

endmodule

// File: tb/tb_keyboard.sv
`timescale 1ns/1ps
// Randomised bench for keyboard: drives PS/2 frames and compares stored frames and segment
// outputs against a two-entry history model built from the frame acceptance rules.
module tb_keyboard;
    localparam int unsigned TO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [6:0] prev_seg1, prev_seg0, curr_seg1, curr_seg0;

    keyboard #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .prev_seg1 (prev_seg1),
        .prev_seg0 (prev_seg0),
        .curr_seg1 (curr_seg1),
        .curr_seg0 (curr_seg0)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] m_curr = '0;
    logic [10:0] m_prev = '0;
    logic [6:0]  seg_ref [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] data, input bit bad_par,
                                               input bit bad_start, input bit stop);
        logic par;
        // Odd parity: data plus parity has an odd number of ones.
        par = ($countones(data) % 2 == 0) ? 1'b1 : 1'b0;
        if (bad_par) par = ~par;
        return {stop, par, data, bad_start};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2d = fr[i];
            #100 ps2c = 1'b0;
            #100 ps2c = 1'b1;
        end
        #100 ps2d = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_start,
                              input bit stop);
        logic [10:0] fr;
        fr = make_frame(data, bad_par, bad_start, stop);
        send_bits(fr, 11);
        if (!bad_par && !bad_start) begin
            m_prev = m_curr;
            m_curr = fr;
        end
    endtask

    task automatic check_all(input string tag);
        repeat (4) @(negedge clk);
        check({tag, ".currb"}, 32'(dut.out_currb), 32'(m_curr));
        check({tag, ".prevb"}, 32'(dut.out_prevb), 32'(m_prev));
        check({tag, ".cs1"}, 32'(curr_seg1), 32'(seg_ref[m_curr[8:5]]));
        check({tag, ".cs0"}, 32'(curr_seg0), 32'(seg_ref[m_curr[4:1]]));
        check({tag, ".ps1"}, 32'(prev_seg1), 32'(seg_ref[m_prev[8:5]]));
        check({tag, ".ps0"}, 32'(prev_seg0), 32'(seg_ref[m_prev[4:1]]));
    endtask

    initial begin
        logic [7:0] d;
        int kind;
        seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Held in reset, then idle after release.
        #33;
        check("rst.cs1", 32'(curr_seg1), 32'h40);
        check("rst.ps0", 32'(prev_seg0), 32'h40);
        rst = 1'b1;
        #200;
        check_all("idle");

        send_frame(8'h1C, 0, 0, 0);
        check_all("f1c");
        check("f1c.cs1_lit", 32'(curr_seg1), 32'h79);
        check("f1c.cs0_lit", 32'(curr_seg0), 32'h46);

        send_frame(8'hE0, 0, 0, 1);
        send_frame(8'h72, 0, 0, 1);
        send_frame(8'hF0, 0, 0, 1);
        send_frame(8'hE0, 0, 0, 1);
        send_frame(8'h72, 0, 0, 1);
        check_all("e072");
        check("e072.ps1_lit", 32'(prev_seg1), 32'h06);
        check("e072.cs1_lit", 32'(curr_seg1), 32'h78);

        send_frame(8'h2A, 1, 0, 1);
        check_all("badpar");

        // Five bits of a frame, then silence longer than the watchdog.
        send_bits(make_frame(8'hAA, 0, 0, 1), 5);
        repeat (TO + 30) @(posedge clk);
        send_frame(8'h45, 0, 0, 1);
        check_all("tmo45");
        check("tmo45.cs0_lit", 32'(curr_seg0), 32'h12);

        send_frame(8'h33, 0, 0, 1);
        check_all("f33");
        send_bits(make_frame(8'h99, 0, 0, 1), 4);
        rst = 1'b0;
        m_curr = '0;
        m_prev = '0;
        #1;
        check("midrst.currb", 32'(dut.out_currb), 32'h0);
        check("midrst.prevb", 32'(dut.out_prevb), 32'h0);
        check("midrst.cs1", 32'(curr_seg1), 32'h40);
        check("midrst.ps1", 32'(prev_seg1), 32'h40);
        #100 rst = 1'b1;
        #100;
        send_frame(8'h16, 0, 0, 1);
        check_all("f16");

        for (int it = 0; it < 40; it++) begin
            d = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                send_frame(d, 0, 0, 1'($urandom));
            end else if (kind == 6) begin
                send_frame(d, 1, 0, 1'($urandom));
            end else if (kind == 7) begin
                send_frame(d, 0, 1, 1'($urandom));
            end else begin
                send_bits(make_frame(d, 0, 0, 1), $urandom_range(1, 10));
                repeat (TO + 30) @(posedge clk);
            end
            check_all($sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
